hour_display_scan: RTL and testbench

//  Display-side consumer of the 24-hour counter: reads the 6-bit binary hour (0..23) and drives a
//  2-digit multiplexed 7-segment display. Converts binary to tens/ones, time-multiplexes the two digit

---
 rtl/hour_display_scan.sv | 172 +++++++++++++++++
 tb/tb_hour_display_scan.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hour_display_scan.sv
// Binary hour (0..23) to a 2-digit multiplexed 7-segment display scan; "--" when out of range.
// Optional blink of the segments in hour-adjust mode when HOUR_BLINK_EN is defined.
module hour_display_scan #(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLINK_DIV = 250
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [5:0] digits,
  input  logic       adjust,
  output logic [6:0] seg,
  output logic [1:0] dig_sel
);

  localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_DASH = 7'h40;

  typedef enum logic [1:0] {BLANK, TENS, ONES} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [5:0]    hour_q, hour_d;
  logic [6:0]    seg_d;
  logic [1:0]    dig_sel_d;
  logic [6:0]    pat;
  logic          tick;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Tens offset of an in-range hour: 0, 10 or 20.
  function automatic logic [5:0] tens_base(input logic [5:0] h);
    logic [5:0] t;
    if (h >= 6'd20)      t = 6'd20;
    else if (h >= 6'd10) t = 6'd10;
    else                 t = 6'd0;
    return t;
  endfunction

  function automatic logic [6:0] tens_pat(input logic [5:0] h);
    logic [6:0] s;
    if (h >= 6'd24)      s = SEG_DASH;
    else if (h >= 6'd20) s = seg_of(4'd2);
    else if (h >= 6'd10) s = seg_of(4'd1);
    else                 s = seg_of(4'd0);
    return s;
  endfunction

  function automatic logic [6:0] ones_pat(input logic [5:0] h);
    logic [6:0] s;
    if (h >= 6'd24) s = SEG_DASH;
    else            s = seg_of(4'(h - tens_base(h)));
    return s;
  endfunction

  assign tick = (pcnt_q == PMAX);

`ifdef HOUR_BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic [6:0]    pat_q, pat_d;
`else
  logic        unused_adjust;
  logic [31:0] unused_blink_div;
  assign unused_adjust    = adjust;
  assign unused_blink_div = BLINK_DIV;
`endif

  // Next-state and registered-output logic; the frame samples digits once per TENS entry.
  always_comb begin
    state_d   = state_q;
    hour_d    = hour_q;
    seg_d     = seg;
    dig_sel_d = dig_sel;
    pat       = 7'h00;
    pcnt_d    = tick ? '0 : pcnt_q + PW'(1);

    if (tick) begin
      case (state_q)
        BLANK, ONES: begin
          state_d   = TENS;
          hour_d    = digits;
          pat       = tens_pat(digits);
          dig_sel_d = 2'b10;
        end
        TENS: begin
          state_d   = ONES;
          pat       = ones_pat(hour_q);
          dig_sel_d = 2'b01;
        end
        default: begin
          state_d   = BLANK;
          dig_sel_d = 2'b00;
        end
      endcase
    end

`ifdef HOUR_BLINK_EN
    pat_d   = pat_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;

    // Blanking is decided per slot; leaving adjust mode restores the slot pattern at once.
    if (tick) begin
      pat_d = pat;
      seg_d = (adjust && phase_q) ? 7'h00 : pat;
    end else if (!adjust) begin
      seg_d = pat_q;
    end

    if (!adjust) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      if (bcnt_q == BMAX) begin
        bcnt_d  = '0;
        phase_d = !phase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
`else
    if (tick) seg_d = pat;
`endif
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= BLANK;
      pcnt_q  <= '0;
      hour_q  <= '0;
      seg     <= 7'h00;
      dig_sel <= 2'b00;
`ifdef HOUR_BLINK_EN
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      pat_q   <= 7'h00;
`endif
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      hour_q  <= hour_d;
      seg     <= seg_d;
      dig_sel <= dig_sel_d;
`ifdef HOUR_BLINK_EN
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      pat_q   <= pat_d;
`endif
    end
  end

endmodule

// File: tb/tb_hour_display_scan.sv
// Self-checking bench for hour_display_scan (SCAN_DIV=4, BLINK_DIV=2), slot-level reference model.
// Expectations follow HOUR_BLINK_EN the same way as the design build.
module tb_hour_display_scan;

  localparam int SD = 4;
  localparam int BD = 2;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic [5:0] digits = 6'd0;
  logic       adjust = 1'b0;
  logic [6:0] seg;
  logic [1:0] dig_sel;

  hour_display_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .clear(clear), .digits(digits), .adjust(adjust),
    .seg(seg), .dig_sel(dig_sel)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: cycles since clear release, latched frame hour, blink bookkeeping.
  int         cyc;
  int         blink_ticks;
  bit         lit;
  bit         cur_tens;
  bit         forced;
  int         latched;
  logic [6:0] exp_seg;
  logic [1:0] exp_dig;
  logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [6:0] model_pat(input int h, input bit tens);
    if (h >= 24) return 7'h40;
    return tens ? tbl[h / 10] : tbl[h % 10];
  endfunction

  task automatic model_reset();
    cyc = 0; blink_ticks = 0; lit = 0; cur_tens = 0; forced = 0; latched = 0;
    exp_seg = 7'h00; exp_dig = 2'b00;
  endtask

  // One clock: sample inputs as the DUT sees them, advance the model, settle at edge+1.
  task automatic advance();
    int d;
    bit a;
    int slot;
    d = int'(digits);
    a = adjust;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc % SD == 0) begin
      slot = cyc / SD;
      lit = 1;
      cur_tens = (slot % 2) == 1;
      if (cur_tens) latched = d;
`ifdef HOUR_BLINK_EN
      if (a) begin
        blink_ticks++;
        forced = (((blink_ticks - 1) / BD) % 2) == 1;
      end
`endif
    end
`ifdef HOUR_BLINK_EN
    if (!a) begin
      blink_ticks = 0;
      forced = 0;
    end
`endif
    exp_seg = (!lit || forced) ? 7'h00 : model_pat(latched, cur_tens);
    exp_dig = !lit ? 2'b00 : (cur_tens ? 2'b10 : 2'b01);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [6:0] es;
    logic [1:0] ed;
    digits = 6'd0;
    adjust = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (seg !== 7'h00 || dig_sel !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_hold seg=%h want 00 dig_sel=%b want 00", seg, dig_sel);
    end
    clear = 1'b0;
    model_reset();
    for (int i = 1; i <= 12; i++) begin
      advance();
      es = (i < 4) ? 7'h00 : 7'h3F;
      ed = (i < 4) ? 2'b00 : (((i / 4) % 2) == 1 ? 2'b10 : 2'b01);
      n_cmp++;
      if (seg !== es || dig_sel !== ed) begin
        n_bad++;
        $display("FAIL reset_start cyc=%0d seg=%h want %h dig_sel=%b want %b", i, seg, es, dig_sel, ed);
      end
    end
  endtask

  task automatic test_steady();
    logic [6:0] cs;
    digits = 6'd23;
    do_clear();
    for (int i = 0; i < 20; i++) begin
      advance();
      cs = (cyc < 4) ? 7'h00 : (((cyc / 4) % 2) == 1 ? 7'h5B : 7'h4F);
      n_cmp++;
      if (seg !== exp_seg || dig_sel !== exp_dig || seg !== cs) begin
        n_bad++;
        $display("FAIL steady23 cyc=%0d seg=%h want %h dig_sel=%b want %b", cyc, seg, cs, dig_sel, exp_dig);
      end
    end
  endtask

  task automatic test_mid_frame_change();
    digits = 6'd17;
    do_clear();
    for (int i = 0; i < 20; i++) begin
      advance();
      if (cyc == 5) digits = 6'd9;
      n_cmp++;
      if (seg !== exp_seg || dig_sel !== exp_dig) begin
        n_bad++;
        $display("FAIL mid_frame cyc=%0d seg=%h want %h dig_sel=%b want %b", cyc, seg, exp_seg, dig_sel, exp_dig);
      end
      if (cyc == 9) begin
        n_cmp++;
        if (seg !== 7'h07 || dig_sel !== 2'b01) begin
          n_bad++;
          $display("FAIL no_tearing seg=%h want 07 dig_sel=%b want 01", seg, dig_sel);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    digits = 6'd30;
    do_clear();
    for (int i = 0; i < 20; i++) begin
      advance();
      if (cyc == 9) digits = 6'd5;
      n_cmp++;
      if (seg !== exp_seg || dig_sel !== exp_dig) begin
        n_bad++;
        $display("FAIL out_of_range cyc=%0d seg=%h want %h dig_sel=%b want %b", cyc, seg, exp_seg, dig_sel, exp_dig);
      end
      if (cyc == 6 || cyc == 10) begin
        n_cmp++;
        if (seg !== 7'h40) begin
          n_bad++;
          $display("FAIL dash cyc=%0d seg=%h want 40", cyc, seg);
        end
      end
    end
  endtask

  task automatic test_async_clear();
    digits = 6'($urandom_range(0, 23));
    do_clear();
    for (int i = 0; i < 9; i++) advance();
    #2;
    clear = 1'b1;
    #1;
    n_cmp++;
    if (seg !== 7'h00 || dig_sel !== 2'b00) begin
      n_bad++;
      $display("FAIL async_clear seg=%h want 00 dig_sel=%b want 00", seg, dig_sel);
    end
    @(negedge clk);
    clear = 1'b0;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      advance();
      n_cmp++;
      if (seg !== exp_seg || dig_sel !== exp_dig) begin
        n_bad++;
        $display("FAIL restart cyc=%0d seg=%h want %h dig_sel=%b want %b", cyc, seg, exp_seg, dig_sel, exp_dig);
      end
    end
  endtask

  task automatic test_blink();
    digits = 6'd12;
    adjust = 1'b1;
    do_clear();
    for (int i = 0; i < 60; i++) begin
      advance();
      if (cyc == 13) adjust = 1'b0;
      if (cyc == 30) adjust = 1'b1;
      n_cmp++;
      if (seg !== exp_seg || dig_sel !== exp_dig) begin
        n_bad++;
        $display("FAIL blink cyc=%0d adj=%b seg=%h want %h dig_sel=%b want %b",
                 cyc, adjust, seg, exp_seg, dig_sel, exp_dig);
      end
    end
  endtask

  task automatic test_random();
    adjust = 1'b0;
    digits = 6'($urandom_range(0, 23));
    do_clear();
    for (int i = 0; i < 600; i++) begin
      advance();
      if ($urandom_range(0, 5) == 0)
        digits = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(24, 63)) : 6'($urandom_range(0, 23));
      if ($urandom_range(0, 15) == 0) adjust = ~adjust;
      n_cmp++;
      if (seg !== exp_seg || dig_sel !== exp_dig) begin
        n_bad++;
        $display("FAIL random cyc=%0d seg=%h want %h dig_sel=%b want %b", cyc, seg, exp_seg, dig_sel, exp_dig);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_steady();
    test_mid_frame_change();
    test_out_of_range();
    test_async_clear();
    test_blink();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
